// File: rtl/gcd_array.sv
// gcd_array: tagged (x, y) requests go to the lowest IDLE lane of LANES subtractive-Euclid engines.
// Latency: S + 2 cycles from the input handshake to the earliest output_valid (S = subtraction steps).
// Backpressure: input_ready is low while no lane is IDLE; a granted result holds stable until output_ready.
module gcd_array #(
    parameter int WIDTH    = 16,
    parameter int LANES    = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic [WIDTH-1:0]    input_bits_x,
    input  logic [WIDTH-1:0]    input_bits_y,
    input  logic [ID_WIDTH-1:0] input_bits_id,
    output logic                output_valid,
    input  logic                output_ready,
    output logic [WIDTH-1:0]    output_bits,
    output logic [ID_WIDTH-1:0] output_bits_id,
    output logic                busy
);
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lane_state_t;

    // Per-lane engine state; x doubles as the result register once the lane is DONE
    typedef struct packed {
        lane_state_t         st;
        logic [WIDTH-1:0]    x;
        logic [WIDTH-1:0]    y;
        logic [ID_WIDTH-1:0] id;
    } lane_t;

    lane_t         lane_q [LANES];
    lane_t         lane_d [LANES];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] grant_q, grant_d;
    logic          lock_q, lock_d;

    logic [PW-1:0] idle_idx;
    logic [PW-1:0] rr_idx;
    logic [PW-1:0] out_idx;
    logic [PW-1:0] hi_idx, lo_idx;
    logic          hi_found;
    logic          in_fire, out_fire;

    // Occupancy flags and lowest-index IDLE lane (scan downwards so the lowest index wins)
    always_comb begin
        input_ready  = 1'b0;
        busy         = 1'b0;
        output_valid = 1'b0;
        idle_idx     = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_q[i].st == IDLE) begin
                input_ready = 1'b1;
                idle_idx    = PW'(i);
            end else begin
                busy = 1'b1;
            end
            if (lane_q[i].st == DONE) begin
                output_valid = 1'b1;
            end
        end
    end

    // Round-robin pick: first DONE lane at index >= ptr, otherwise wrap to the lowest DONE lane;
    // a locked grant overrides the pick so a presented result cannot change under backpressure
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_q[i].st == DONE) begin
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end else begin
                    lo_idx = PW'(i);
                end
            end
        end
        rr_idx  = hi_found ? hi_idx : lo_idx;
        out_idx = lock_q ? grant_q : rr_idx;
    end

    // Result presentation; driven to zero whenever nothing is pending
    always_comb begin
        output_bits    = '0;
        output_bits_id = '0;
        if (output_valid) begin
            output_bits    = lane_q[out_idx].x;
            output_bits_id = lane_q[out_idx].id;
        end
    end

    // Engine steps, result hand-off with round-robin advance, grant locking and dispatch
    always_comb begin
        lane_d   = lane_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        lock_d   = lock_q;
        in_fire  = input_valid && input_ready;
        out_fire = output_valid && output_ready;

        for (int i = 0; i < LANES; i++) begin
            if (lane_q[i].st == RUN) begin
                if (lane_q[i].y == '0) begin
                    lane_d[i].st = DONE;
                end else if (lane_q[i].x == '0) begin
                    lane_d[i].x  = lane_q[i].y;
                    lane_d[i].st = DONE;
                end else if (lane_q[i].x > lane_q[i].y) begin
                    lane_d[i].x = lane_q[i].x - lane_q[i].y;
                end else begin
                    lane_d[i].y = lane_q[i].y - lane_q[i].x;
                end
            end
        end

        if (out_fire) begin
            lane_d[out_idx].st = IDLE;
            ptr_d  = (out_idx == PW'(LANES - 1)) ? '0 : out_idx + 1'b1;
            lock_d = 1'b0;
        end else if (output_valid && !lock_q) begin
            lock_d  = 1'b1;
            grant_d = rr_idx;
        end

        // A lane freed by this cycle's hand-off is still DONE here, so it is never picked
        if (in_fire) begin
            lane_d[idle_idx].st = RUN;
            lane_d[idle_idx].x  = input_bits_x;
            lane_d[idle_idx].y  = input_bits_y;
            lane_d[idle_idx].id = input_bits_id;
        end
    end

    // State registers; reset discards every in-flight request and result
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i].st <= IDLE;
                lane_q[i].x  <= '0;
                lane_q[i].y  <= '0;
                lane_q[i].id <= '0;
            end
            ptr_q   <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
        end
    end
endmodule

// File: tb/tb_gcd_array.sv
// tb_gcd_array: directed and randomized checks of gcd_array against a Euclid reference model.
// Latency: expected result cycle = acceptance cycle + (sum of Euclid quotients) + 2.
// Backpressure: output_ready is held low or randomized to exercise grant locking and lane reuse.
module tb_gcd_array;
    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int IDW   = 4;
    localparam int NR    = 40;

    logic             clock = 1'b0;
    logic             reset;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] input_bits_x;
    logic [WIDTH-1:0] input_bits_y;
    logic [IDW-1:0]   input_bits_id;
    logic             output_valid;
    logic             output_ready;
    logic [WIDTH-1:0] output_bits;
    logic [IDW-1:0]   output_bits_id;
    logic             busy;

    typedef struct {
        int id;
        int val;
        int cyc;
    } res_t;

    res_t got[$];
    int   acc_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    gcd_array #(.WIDTH(WIDTH), .LANES(LANES), .ID_WIDTH(IDW)) dut (
        .clock          (clock),
        .reset          (reset),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .input_bits_x   (input_bits_x),
        .input_bits_y   (input_bits_y),
        .input_bits_id  (input_bits_id),
        .output_valid   (output_valid),
        .output_ready   (output_ready),
        .output_bits    (output_bits),
        .output_bits_id (output_bits_id),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: gcd by the modulo form of Euclid
    function automatic int model_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtraction count of the subtractive algorithm = sum of Euclid quotients (0 if an operand is 0)
    function automatic int model_steps(input int a, input int b);
        int s;
        int t;
        s = 0;
        if (a == 0 || b == 0) return 0;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes mid-cycle, then move to the next falling edge
    task automatic step();
        res_t r;
        #2;
        if (!reset && output_valid && output_ready) begin
            r.id  = int'(output_bits_id);
            r.val = int'(output_bits);
            r.cyc = cyc;
            got.push_back(r);
        end
        if (!reset && input_valid && input_ready) acc_q.push_back(cyc);
        @(negedge clock);
        cyc++;
    endtask

    task automatic drive(input int x, input int y, input int id);
        input_bits_x  = WIDTH'(x);
        input_bits_y  = WIDTH'(y);
        input_bits_id = IDW'(id);
        input_valid   = 1'b1;
    endtask

    task automatic wait_res(input int n, input int bound, input string tag);
        int w;
        w = 0;
        while (got.size() < n && w < bound) begin
            step();
            w++;
        end
        check(tag, got.size() >= n, 1);
    endtask

    initial begin
        int   zx[3] = '{0, 7, 0};
        int   zy[3] = '{9, 0, 0};
        int   bx[5] = '{48, 100, 17, 12, 9};
        int   by[5] = '{18, 75, 5, 8, 3};
        int   cx[3] = '{65535, 65535, 65535};
        int   cy[3] = '{65535, 1, 32768};
        int   exp_val[16];
        int   pend[16];
        int   w, bad, hv, hid, k, rcv, rx, ry, j;
        res_t r;

        reset         = 1'b1;
        input_valid   = 1'b0;
        input_bits_x  = '0;
        input_bits_y  = '0;
        input_bits_id = '0;
        output_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_val[i] = 0;
            pend[i]    = 0;
        end
        @(negedge clock);
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_input_ready", input_ready, 1);
        check("rst_output_valid", output_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_output_bits", output_bits, 0);
        check("rst_output_id", output_bits_id, 0);

        // Single request (48,18,id3)
        drive(48, 18, 3);
        step();
        input_valid = 1'b0;
        wait_res(1, 50, "single_wait");
        check("single_val", got[0].val, model_gcd(48, 18));
        check("single_id", got[0].id, 3);
        check("single_lat", got[0].cyc, acc_q[0] + model_steps(48, 18) + 2);
        check("single_busy_after", busy, 0);

        // Zero operands back to back
        got.delete();
        acc_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(zx[i], zy[i], i);
            step();
        end
        input_valid = 1'b0;
        wait_res(3, 20, "zero_wait");
        for (int i = 0; i < 3; i++) begin
            check("zero_id", got[i].id, i);
            check("zero_val", got[i].val, model_gcd(zx[i], zy[i]));
            check("zero_lat", got[i].cyc, acc_q[i] + model_steps(zx[i], zy[i]) + 2);
        end

        // Full occupancy with backpressure, starting from a fresh round-robin pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        got.delete();
        acc_q.delete();
        output_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(bx[i], by[i], 4 + i);
            step();
        end
        drive(bx[4], by[4], 8);
        check("full_input_ready", input_ready, 0);
        check("full_accepted", acc_q.size(), 4);
        w = 0;
        while (!output_valid && w < 40) begin
            step();
            w++;
        end
        check("bp_valid", output_valid, 1);
        hv  = int'(output_bits);
        hid = int'(output_bits_id);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (output_valid !== 1'b1 || output_bits !== WIDTH'(hv) || output_bits_id !== IDW'(hid)) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_first_id", hid, 4);
        check("bp_first_val", hv, model_gcd(bx[0], by[0]));
        check("bp_fifth_held", acc_q.size(), 4);
        output_ready = 1'b1;
        w = 0;
        while (got.size() < 5 && w < 60) begin
            step();
            if (acc_q.size() >= 5) input_valid = 1'b0;
            w++;
        end
        input_valid = 1'b0;
        check("drain_wait", got.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            check("drain_id", got[i].id, 4 + i);
            check("drain_val", got[i].val, model_gcd(bx[i], by[i]));
        end
        check("fifth_after_first_drain", acc_q[4], got[0].cyc + 1);

        // Out-of-order completion
        got.delete();
        acc_q.delete();
        drive(1000, 1, 1);
        step();
        drive(6, 6, 2);
        step();
        input_valid = 1'b0;
        wait_res(2, 1100, "ooo_wait");
        check("ooo_first_id", got[0].id, 2);
        check("ooo_first_val", got[0].val, model_gcd(6, 6));
        check("ooo_first_lat", got[0].cyc, acc_q[1] + model_steps(6, 6) + 2);
        check("ooo_second_id", got[1].id, 1);
        check("ooo_second_val", got[1].val, model_gcd(1000, 1));
        check("ooo_second_lat", got[1].cyc, acc_q[0] + model_steps(1000, 1) + 2);

        // Reset mid-operation: one lane DONE (held), three lanes RUN
        got.delete();
        acc_q.delete();
        output_ready = 1'b0;
        drive(6, 6, 9);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1000, 1, 10 + i);
            step();
        end
        input_valid = 1'b0;
        check("midrst_pre_valid", output_valid, 1);
        check("midrst_pre_ready", input_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", output_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_input_ready", input_ready, 1);
        check("midrst_bits", output_bits, 0);
        output_ready = 1'b1;
        for (int i = 0; i < 1100; i++) step();
        check("midrst_no_stale", got.size(), 0);

        // Randomized traffic with random backpressure
        got.delete();
        acc_q.delete();
        k   = 0;
        rcv = 0;
        for (int c = 0; c < 8000 && rcv < NR; c++) begin
            if (!input_valid && k < NR && $urandom_range(0, 3) != 0) begin
                rx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
                ry = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
                exp_val[k % 16] = model_gcd(rx, ry);
                drive(rx, ry, k % 16);
            end
            output_ready = ($urandom_range(0, 9) < 7);
            step();
            if (acc_q.size() > 0) begin
                void'(acc_q.pop_front());
                pend[k % 16] = 1;
                k++;
                input_valid = 1'b0;
            end
            while (got.size() > 0) begin
                r = got.pop_front();
                check("rnd_pending", pend[r.id % 16], 1);
                check("rnd_val", r.val, exp_val[r.id % 16]);
                pend[r.id % 16] = 0;
                rcv++;
            end
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        check("rnd_count", rcv, NR);

        // Width corners, run concurrently in separate lanes
        got.delete();
        acc_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(cx[i], cy[i], i);
            step();
        end
        input_valid = 1'b0;
        wait_res(3, 70000, "corner_wait");
        for (int i = 0; i < got.size(); i++) begin
            check("corner_id_range", got[i].id < 3, 1);
            j = got[i].id % 3;
            check("corner_val", got[i].val, model_gcd(cx[j], cy[j]));
            check("corner_lat", got[i].cyc, acc_q[j] + model_steps(cx[j], cy[j]) + 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gcd_array.md
# gcd_array

Multi-lane, parametrised successor to the single-engine GCD. It accepts tagged (x, y) operand pairs over a valid/ready input port and dispatches each pair to one of LANES independent subtractive-Euclid engines. Each result is returned with its tag over a valid/ready output port that honours backpressure. Results may complete out of order, and the tag identifies which request each result belongs to. The block sits where the GCD core sits today and drives the same busy probe for the bench.

## Interface
- WIDTH, 16: operand and result width in bits.
- LANES, 4: number of parallel GCD engines, ≥1.
- ID_WIDTH, 4: request tag width, ≥1.

- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- input_valid  in  1  request present.
- input_ready  out  1  block can accept a request this cycle.
- input_bits_x  in  WIDTH  operand x, unsigned.
- input_bits_y  in  WIDTH  operand y, unsigned.
- input_bits_id  in  ID_WIDTH  request tag, returned unchanged.
- output_valid  out  1  result present.
- output_ready  in  1  consumer accepts result.
- output_bits  out  WIDTH  gcd(x, y).
- output_bits_id  out  ID_WIDTH  tag of the request that produced output_bits.
- busy  out  1  at least one lane is not IDLE (bench probe).

## Operation
- Each lane has its own state machine with states IDLE, RUN and DONE, plus registers x, y (WIDTH bits) and id.
- input_ready = OR of (lane == IDLE), computed combinationally.
- **Dispatch:** an input handshake loads the lowest-index IDLE lane with x, y and id, and moves that lane to RUN.
- **RUN, one step per cycle, first matching rule wins:**
  - y == 0: result = x, go to DONE.
  - x == 0: result = y, go to DONE.
  - x > y: x ← x − y.
  - otherwise: y ← y − x.
- **Arithmetic:** unsigned, WIDTH bits, no overflow is possible. gcd(0,0) = 0, gcd(0,n) = n, gcd(n,0) = n.
- **Draining DONE lanes:** output_valid = any lane in DONE. A round-robin pointer `ptr` (log2 LANES bits) selects the first DONE lane at index ≥ ptr, wrapping around.
- **Grant lock:** once output_valid rises, the selected lane is locked. output_bits and output_bits_id hold stable until the output handshake, even if other lanes reach DONE in the meantime.
- **On output handshake:**
  - the granted lane returns to IDLE;
  - ptr ← (granted + 1) mod LANES;
  - the lock is released.
- **Lane reuse:** a lane that hands off its result in cycle T is not available for dispatch until cycle T+1. input_ready in cycle T does not account for it.
- busy = OR of (lane != IDLE).
- **Reset:**
  - every lane goes to IDLE and in-flight results are discarded;
  - ptr = 0 and the lock is cleared;
  - outputs after reset: input_ready = 1, output_valid = 0, busy = 0, output_bits = 0, output_bits_id = 0.
  - Asserting reset mid-operation behaves identically.

## Timing
- **Latency:** if an input handshake occurs in cycle T, that lane reaches DONE and can raise output_valid at the earliest in cycle T + S + 2, where S is the number of subtraction steps.
  - Example (48,18): S = 5, so output_valid at T+7.
  - The zero-operand cases have S = 0, so latency is T+2.
- **Throughput:** one request accepted per cycle while any lane is IDLE, and one result returned per cycle while any lane is DONE.
- Input acceptance and output return in the same cycle are independent and both permitted.
- **All lanes busy:** input_ready = 0. input_bits_* are ignored and the upstream requester must hold them.
- **Backpressure:** output_valid stays high with data stable while output_ready = 0. Lanes in DONE hold their results indefinitely.
- **Flag timing:** input_ready, output_valid, output_bits and busy are combinational from registered state only. No combinational path exists from input_valid to input_ready, or from output_ready to output_valid.

## Test plan
- **Single request:** reset for 2 cycles, then (48,18,id=3) accepted in cycle T with output_ready=1.
  - Expect output_valid first in T+7, with output_bits=6 and output_bits_id=3.
  - busy=0 from T+8.
- **Zero operands:** send (0,9,id0), (7,0,id1) and (0,0,id2) in back-to-back cycles.
  - Expect results 9, 7, 0 on ids 0, 1, 2.
  - Each result appears 2 cycles after its acceptance.
- **Full occupancy with backpressure** (LANES=4), holding output_ready=0:
  - send 4 requests; input_ready drops after the 4th, and a 5th request is not accepted;
  - output_valid stays high with a constant bits/id for ≥10 cycles;
  - release output_ready: all 4 results drain, the 5th request is accepted only after the first drain, and the grant order is round-robin starting at lane 0.
- **Out-of-order completion:** send (1000,1,id=1), then (6,6,id=2) one cycle later.
  - Expect id=2 with result 6 first, then id=1 with result 1 after 1000 subtraction steps.
- **Reset mid-operation:** 3 lanes in RUN and 1 lane in DONE with output_ready=0, then reset asserted for 1 cycle.
  - In the cycle after reset: output_valid=0, busy=0, input_ready=1.
  - No stale result ever appears afterwards.
- **Width corner:** (65535,65535) returns 65535 at T+3; (65535,1) returns 1; (0xFFFF,0x8000) returns 1.
